commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
- Retire-point observer between the pipelined processor's writeback stage and the simulation bench.
- Registers one committed instruction per cycle into a stable, single-cycle-valid commit record (PC, instruction, register write, memory access, halt).
- Maintains instruction and cycle counts, a sticky halt, and a no-commit watchdog, so the bench never probes internal pipeline stages or counts bubbles as instructions.

Parameters:
- CNT_W, 32, width of inst_count and cycle_count.
- TIMEOUT, 1024, consecutive non-commit cycles before stall_timeout sets; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  a real instruction retires this cycle; 0 means bubble or squash.
- wb_pc  in  16  PC of the retiring instruction.
- wb_instr  in  16  instruction word.
- wb_regwrite  in  1  register file write enable.
- wb_wreg  in  3  destination register.
- wb_wdata  in  16  register write data.
- wb_memread  in  1  load.
- wb_memwrite  in  1  store.
- wb_memaddr  in  16  memory address.
- wb_memdata  in  16  store data.
- wb_halt  in  1  HALT retiring.
- cm_valid  out  1  commit record valid, one cycle per instruction.
- cm_pc, cm_instr, cm_wdata, cm_memaddr, cm_memdata  out  16 each  registered copies of the inputs.
- cm_regwrite, cm_memread, cm_memwrite, cm_halt  out  1 each  registered copies.
- cm_wreg  out  3  registered copy.
- inst_count  out  CNT_W  committed instructions since reset, HALT included.
- cycle_count  out  CNT_W  cycles since reset.
- halted  out  1  sticky; a HALT has committed.
- err_post_halt  out  1  sticky; wb_valid seen after halted.
- stall_timeout  out  1  sticky; watchdog expired.

Behaviour:
- Reset: on a rising clk with rst=1, every output and internal counter clears to 0.
- Latency: exactly one cycle. A wb_valid sampled at edge N gives cm_valid=1 with all cm_* fields equal to the edge-N inputs for the cycle following edge N.
- cm_* fields:
  - Load only when a commit is accepted.
  - Otherwise hold their last value while cm_valid=0.
- Accepted commit: wb_valid=1 and halted=0.
- Control qualification: cm_regwrite, cm_memread, cm_memwrite and cm_halt are forced to 0 whenever cm_valid=0.
- inst_count:
  - +1 per accepted commit, updated on the same edge cm_valid rises.
  - Saturates at all-ones.
- cycle_count:
  - +1 every non-reset edge until halted=1, then frozen.
  - Saturates at all-ones.
  - The HALT edge itself increments.
- halted:
  - Sets on the edge accepting a commit with wb_halt=1; that commit is still reported with cm_halt=1.
  - Clears only on rst.
- After halted=1:
  - wb_valid=1 is not accepted: cm_valid stays 0 and inst_count is unchanged.
  - err_post_halt sets on that edge.
- Watchdog:
  - An idle counter clears on every accepted commit and increments on every non-commit edge while halted=0.
  - When it reaches TIMEOUT, stall_timeout sets (sticky) and the counter stops.
  - The watchdog is disabled once halted=1.
- Inconsistent inputs are recorded as-is, no error flagged:
  - wb_valid=0 with other wb_* asserted is ignored entirely.
  - wb_memread and wb_memwrite both set.
  - wb_regwrite together with wb_memwrite (stu) is a legal record.
- Reset mid-stream: rst has priority over every accept, count and flag update on the same edge.

Test Plan:
- Reset, then commit PC=0x0000 addi (wb_regwrite=1, wreg=3, wdata=0x0005) -> next cycle cm_valid=1, cm_pc=0x0000, cm_wreg=3, cm_wdata=0x0005, inst_count=1, cycle_count=2.
- 4 commits with bubbles after commits 2 and 3 (wb_valid=1,1,0,1,0,1) -> cm_valid pulses exactly 4 times; inst_count=4; cm_* fields hold during bubbles; cm_regwrite=0 when cm_valid=0.
- Store then stu: (memwrite, addr=0x0010, data=0xBEEF), then (regwrite + memwrite, wreg=2) -> both records exact; err flags 0.
- HALT at PC=0x0020, then wb_valid=1 the next cycle -> cm_halt=1 for one cycle; halted=1; inst_count frozen at the HALT count; cycle_count frozen; err_post_halt=1 one edge after the extra wb_valid.
- TIMEOUT=8, one commit then 8 idle edges -> stall_timeout=1 after the 8th idle edge, not after the 7th; a later commit does not clear it.
- rst asserted in the same cycle as a wb_valid=1 with wb_halt=1 -> all outputs 0 next cycle; halted=0; inst_count=0.

Source files
------------

// File: rtl/commit_monitor.sv
// Retire-point observer: turns the writeback stage into a one-cycle-valid commit
// record and tracks instruction/cycle counts, a sticky halt and a no-commit watchdog.
module commit_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [15:0]      wb_pc,
  input  logic [15:0]      wb_instr,
  input  logic             wb_regwrite,
  input  logic [2:0]       wb_wreg,
  input  logic [15:0]      wb_wdata,
  input  logic             wb_memread,
  input  logic             wb_memwrite,
  input  logic [15:0]      wb_memaddr,
  input  logic [15:0]      wb_memdata,
  input  logic             wb_halt,
  output logic             cm_valid,
  output logic [15:0]      cm_pc,
  output logic [15:0]      cm_instr,
  output logic [15:0]      cm_wdata,
  output logic [15:0]      cm_memaddr,
  output logic [15:0]      cm_memdata,
  output logic             cm_regwrite,
  output logic             cm_memread,
  output logic             cm_memwrite,
  output logic             cm_halt,
  output logic [2:0]       cm_wreg,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic             err_post_halt,
  output logic             stall_timeout
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  logic             cm_valid_q;
  logic [15:0]      cm_pc_q, cm_instr_q, cm_wdata_q, cm_memaddr_q, cm_memdata_q;
  logic             cm_regwrite_q, cm_memread_q, cm_memwrite_q, cm_halt_q;
  logic [2:0]       cm_wreg_q;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic             accept;

  // Nothing retires once a HALT has committed.
  assign accept = wb_valid & ~halted_q;

  // Commit record: fields load only on an accepted commit and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cm_valid_q    <= 1'b0;
      cm_pc_q       <= '0;
      cm_instr_q    <= '0;
      cm_wdata_q    <= '0;
      cm_memaddr_q  <= '0;
      cm_memdata_q  <= '0;
      cm_regwrite_q <= 1'b0;
      cm_memread_q  <= 1'b0;
      cm_memwrite_q <= 1'b0;
      cm_halt_q     <= 1'b0;
      cm_wreg_q     <= '0;
    end else begin
      cm_valid_q <= accept;
      if (accept) begin
        cm_pc_q       <= wb_pc;
        cm_instr_q    <= wb_instr;
        cm_wdata_q    <= wb_wdata;
        cm_memaddr_q  <= wb_memaddr;
        cm_memdata_q  <= wb_memdata;
        cm_regwrite_q <= wb_regwrite;
        cm_memread_q  <= wb_memread;
        cm_memwrite_q <= wb_memwrite;
        cm_halt_q     <= wb_halt;
        cm_wreg_q     <= wb_wreg;
      end
    end
  end

  // Next-state for counters, sticky flags and the idle watchdog.
  always_comb begin
    inst_count_d  = inst_count_q;
    cycle_count_d = cycle_count_q;
    idle_d        = idle_q;
    stall_d       = stall_q;
    halted_d      = halted_q | (accept & wb_halt);
    err_d         = err_q | (wb_valid & halted_q);
    if (accept && inst_count_q != CntMax) begin
      inst_count_d = inst_count_q + 1'b1;
    end
    // The HALT edge itself still counts because halted_q is still low there.
    if (!halted_q && cycle_count_q != CntMax) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
    if (!halted_q) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q != TimeoutCnt) begin
        idle_d = idle_q + 1'b1;
        if (idle_d == TimeoutCnt) begin
          stall_d = 1'b1;
        end
      end
    end
  end

  // State update; reset overrides every accept, count and flag on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      idle_q        <= '0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      idle_q        <= idle_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
      stall_q       <= stall_d;
    end
  end

  assign cm_valid      = cm_valid_q;
  assign cm_pc         = cm_pc_q;
  assign cm_instr      = cm_instr_q;
  assign cm_wdata      = cm_wdata_q;
  assign cm_memaddr    = cm_memaddr_q;
  assign cm_memdata    = cm_memdata_q;
  assign cm_wreg       = cm_wreg_q;
  // Control bits are only meaningful alongside a valid record.
  assign cm_regwrite   = cm_regwrite_q & cm_valid_q;
  assign cm_memread    = cm_memread_q & cm_valid_q;
  assign cm_memwrite   = cm_memwrite_q & cm_valid_q;
  assign cm_halt       = cm_halt_q & cm_valid_q;
  assign inst_count    = inst_count_q;
  assign cycle_count   = cycle_count_q;
  assign halted        = halted_q;
  assign err_post_halt = err_q;
  assign stall_timeout = stall_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the retire observer.
module tb_commit_monitor;

  localparam int unsigned CW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic wb_valid, wb_regwrite, wb_memread, wb_memwrite, wb_halt;
  logic [15:0] wb_pc, wb_instr, wb_wdata, wb_memaddr, wb_memdata;
  logic [2:0] wb_wreg;
  logic cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
  logic [15:0] cm_pc, cm_instr, cm_wdata, cm_memaddr, cm_memdata;
  logic [2:0] cm_wreg;
  logic [CW-1:0] inst_count, cycle_count;
  logic halted, err_post_halt, stall_timeout;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  commit_monitor #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_memread(wb_memread), .wb_memwrite(wb_memwrite),
    .wb_memaddr(wb_memaddr), .wb_memdata(wb_memdata), .wb_halt(wb_halt),
    .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_instr(cm_instr), .cm_wdata(cm_wdata),
    .cm_memaddr(cm_memaddr), .cm_memdata(cm_memdata),
    .cm_regwrite(cm_regwrite), .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
    .cm_halt(cm_halt), .cm_wreg(cm_wreg),
    .inst_count(inst_count), .cycle_count(cycle_count),
    .halted(halted), .err_post_halt(err_post_halt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model state: last accepted record plus counters as plain integers.
  bit          m_valid, m_halted, m_err, m_stall;
  longint      m_inst, m_cycles, m_idle;
  logic [15:0] m_pc, m_instr, m_wdata, m_addr, m_mdata;
  logic [2:0]  m_wreg;
  bit          m_rw, m_mr, m_mw, m_halt;
  localparam longint CntMax = (64'd1 << CW) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs sampled at this edge.
  always @(posedge clk) begin
    bit was_halted;
    was_halted = m_halted;
    if (rst) begin
      m_valid = 0; m_halted = 0; m_err = 0; m_stall = 0;
      m_inst = 0; m_cycles = 0; m_idle = 0;
      m_pc = 0; m_instr = 0; m_wdata = 0; m_addr = 0; m_mdata = 0; m_wreg = 0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0;
    end else begin
      m_valid = wb_valid && !was_halted;
      if (!was_halted && m_cycles < CntMax) m_cycles++;
      if (wb_valid && was_halted) m_err = 1;
      if (m_valid) begin
        m_pc = wb_pc; m_instr = wb_instr; m_wdata = wb_wdata; m_addr = wb_memaddr;
        m_mdata = wb_memdata; m_wreg = wb_wreg; m_rw = wb_regwrite; m_mr = wb_memread;
        m_mw = wb_memwrite; m_halt = wb_halt;
        if (m_inst < CntMax) m_inst++;
        m_idle = 0;
        if (wb_halt) m_halted = 1;
      end else if (!was_halted) begin
        if (m_idle < TO) m_idle++;
        if (m_idle == TO) m_stall = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cm_valid", 64'(cm_valid), 64'(m_valid));
      chk("cm_pc", 64'(cm_pc), 64'(m_pc));
      chk("cm_instr", 64'(cm_instr), 64'(m_instr));
      chk("cm_wdata", 64'(cm_wdata), 64'(m_wdata));
      chk("cm_memaddr", 64'(cm_memaddr), 64'(m_addr));
      chk("cm_memdata", 64'(cm_memdata), 64'(m_mdata));
      chk("cm_wreg", 64'(cm_wreg), 64'(m_wreg));
      chk("cm_regwrite", 64'(cm_regwrite), 64'(m_rw && m_valid));
      chk("cm_memread", 64'(cm_memread), 64'(m_mr && m_valid));
      chk("cm_memwrite", 64'(cm_memwrite), 64'(m_mw && m_valid));
      chk("cm_halt", 64'(cm_halt), 64'(m_halt && m_valid));
      chk("inst_count", 64'(inst_count), 64'(m_inst));
      chk("cycle_count", 64'(cycle_count), 64'(m_cycles));
      chk("halted", 64'(halted), 64'(m_halted));
      chk("err_post_halt", 64'(err_post_halt), 64'(m_err));
      chk("stall_timeout", 64'(stall_timeout), 64'(m_stall));
    end
  end

  task automatic set_idle();
    wb_valid = 0; wb_pc = 0; wb_instr = 0; wb_regwrite = 0; wb_wreg = 0; wb_wdata = 0;
    wb_memread = 0; wb_memwrite = 0; wb_memaddr = 0; wb_memdata = 0; wb_halt = 0;
  endtask

  task automatic set_rand(input bit v);
    wb_valid = v; wb_pc = 16'($urandom); wb_instr = 16'($urandom);
    wb_regwrite = 1'($urandom); wb_wreg = 3'($urandom); wb_wdata = 16'($urandom);
    wb_memread = 1'($urandom); wb_memwrite = 1'($urandom);
    wb_memaddr = 16'($urandom); wb_memdata = 16'($urandom); wb_halt = 0;
  endtask

  // One clock edge; returns 1 time unit after it so outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; set_idle(); step(); rst = 0;
  endtask

  int pulses;

  initial begin
    rst = 1;
    set_idle();
    step();
    check_en = 1;
    chk("reset cm_valid", 64'(cm_valid), 64'd0);
    chk("reset inst_count", 64'(inst_count), 64'd0);
    rst = 0;

    // First commit after one idle edge: addi r3 <- 5 at PC 0.
    set_idle(); step();
    set_idle(); wb_valid = 1; wb_pc = 16'h0000; wb_instr = 16'h1345;
    wb_regwrite = 1; wb_wreg = 3; wb_wdata = 16'h0005;
    step();
    chk("addi cm_valid", 64'(cm_valid), 64'd1);
    chk("addi cm_pc", 64'(cm_pc), 64'h0000);
    chk("addi cm_wreg", 64'(cm_wreg), 64'd3);
    chk("addi cm_wdata", 64'(cm_wdata), 64'h0005);
    chk("addi inst_count", 64'(inst_count), 64'd1);
    chk("addi cycle_count", 64'(cycle_count), 64'd2);

    // Commits with bubbles: 1,1,0,1,0,1.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bit v;
      v = (i != 2 && i != 4);
      set_rand(v);
      wb_regwrite = 1;
      step();
      if (cm_valid) pulses++;
      if (!v) chk("bubble cm_regwrite", 64'(cm_regwrite), 64'd0);
    end
    chk("bubble pulses", 64'(pulses), 64'd4);
    chk("bubble inst_count", 64'(inst_count), 64'd4);

    // Store, then stu.
    set_idle(); wb_valid = 1; wb_memwrite = 1; wb_memaddr = 16'h0010; wb_memdata = 16'hBEEF;
    step();
    chk("store cm_memwrite", 64'(cm_memwrite), 64'd1);
    chk("store cm_memaddr", 64'(cm_memaddr), 64'h0010);
    chk("store cm_memdata", 64'(cm_memdata), 64'hBEEF);
    chk("store cm_regwrite", 64'(cm_regwrite), 64'd0);
    set_idle(); wb_valid = 1; wb_regwrite = 1; wb_memwrite = 1; wb_wreg = 2;
    wb_wdata = 16'h0014; wb_memaddr = 16'h0014; wb_memdata = 16'h1234;
    step();
    chk("stu cm_regwrite", 64'(cm_regwrite), 64'd1);
    chk("stu cm_memwrite", 64'(cm_memwrite), 64'd1);
    chk("stu cm_wreg", 64'(cm_wreg), 64'd2);
    chk("stu err_post_halt", 64'(err_post_halt), 64'd0);

    // HALT then an extra retire.
    do_reset();
    set_rand(1); step();
    set_rand(1); step();
    set_idle(); wb_valid = 1; wb_pc = 16'h0020; wb_halt = 1; step();
    chk("halt cm_halt", 64'(cm_halt), 64'd1);
    chk("halt halted", 64'(halted), 64'd1);
    chk("halt inst_count", 64'(inst_count), 64'd3);
    chk("halt err_post_halt", 64'(err_post_halt), 64'd0);
    set_rand(1); step();
    chk("post-halt cm_valid", 64'(cm_valid), 64'd0);
    chk("post-halt cm_halt", 64'(cm_halt), 64'd0);
    chk("post-halt err", 64'(err_post_halt), 64'd1);
    set_idle(); step(); step();
    chk("post-halt inst_count", 64'(inst_count), 64'd3);
    chk("post-halt cycle_count", 64'(cycle_count), 64'd3);

    // Watchdog boundary: 7 idle edges stay clear, the 8th sets.
    do_reset();
    set_rand(1); step();
    set_idle();
    for (int i = 0; i < 7; i++) step();
    chk("wdog 7 idle", 64'(stall_timeout), 64'd0);
    step();
    chk("wdog 8 idle", 64'(stall_timeout), 64'd1);
    set_rand(1); step();
    chk("wdog sticky", 64'(stall_timeout), 64'd1);

    // Randomized traffic with occasional HALTs and resets.
    for (int blk = 0; blk < 10; blk++) begin
      int thr;
      thr = $urandom_range(0, 10);
      for (int i = 0; i < 40; i++) begin
        set_rand($urandom_range(0, 9) < thr);
        wb_halt = ($urandom_range(0, 40) == 0);
        rst = ($urandom_range(0, 60) == 0);
        step();
      end
      rst = 0;
    end

    // Reset wins over a simultaneous HALT commit.
    rst = 0;
    set_rand(1); step();
    rst = 1; set_rand(1); wb_halt = 1; step();
    chk("rst+halt cm_valid", 64'(cm_valid), 64'd0);
    chk("rst+halt halted", 64'(halted), 64'd0);
    chk("rst+halt inst_count", 64'(inst_count), 64'd0);
    chk("rst+halt cycle_count", 64'(cycle_count), 64'd0);
    chk("rst+halt cm_pc", 64'(cm_pc), 64'd0);
    rst = 0; set_idle(); step();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
